// File: rtl/as5600_i2c_target_if.sv
// Bus bundle for the AS5600 I2C target: SCL, angle source and status outputs.
// SDA is an open-drain inout, so it stays a plain pin on the target module.
interface as5600_i2c_target_if;
  logic        scl;
  logic [11:0] raw_angle;
  logic [7:0]  reg_ptr;
  logic        busy;
  logic        read_done;

  modport master (output scl, raw_angle, input reg_ptr, busy, read_done);
  modport slave  (input scl, raw_angle, output reg_ptr, busy, read_done);
endinterface

// File: rtl/as5600_i2c_target.sv
// AS5600 angle-register emulator behind an oversampled I2C target port.
// SDA is open-drain: the target only ever pulls it low or releases it.
module as5600_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h36
) (
  input  logic               clock,
  input  logic               reset_n,
  as5600_i2c_target_if.slave bus,
  inout  wire                sda
);
  localparam int unsigned ANGLE_W = 12;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {IDLE, ADDR, ACK, PTR, TX, WAIT} state_t;

  state_t              state;
  logic [1:0]          scl_sync, sda_sync;
  logic                scl_q, sda_q;
  logic                sda_low;
  logic [BYTE_W-2:0]   shift;
  logic [BYTE_W-1:0]   tx_byte, reg_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [ANGLE_W-1:0]  snapshot;
  logic                rw, ack_drv, ptr_loaded, done_flag, busy, read_done;

  logic                scl_s, sda_s, scl_rise_c, scl_fall_c, start_c, stop_c, tx_bit_c;
  logic [BYTE_W-1:0]   byte_in_c, cur_byte_c, nxt_byte_c;

  function automatic logic [BYTE_W-1:0] reg_byte(input logic [BYTE_W-1:0]  ptr,
                                                 input logic [ANGLE_W-1:0] snap);
    case (ptr)
      8'h0C, 8'h0E: reg_byte = {4'h0, snap[11:8]};
      8'h0D, 8'h0F: reg_byte = snap[7:0];
      default:      reg_byte = '0;
    endcase
  endfunction

  assign scl_s      = scl_sync[1];
  assign sda_s      = sda_sync[1];
  assign scl_rise_c = scl_s & ~scl_q;
  assign scl_fall_c = ~scl_s & scl_q;
  assign start_c    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_c     = scl_s & scl_q & ~sda_q & sda_s;
  assign byte_in_c  = {shift, sda_s};
  assign cur_byte_c = reg_byte(reg_ptr, snapshot);
  assign nxt_byte_c = reg_byte(reg_ptr + 8'd1, snapshot);
  assign tx_bit_c   = tx_byte[~cnt[2:0]];

  assign sda           = sda_low ? 1'b0 : 1'bz;
  assign bus.reg_ptr   = reg_ptr;
  assign bus.busy      = busy;
  assign bus.read_done = read_done;

  // Two-flop synchronizers plus previous-value flops for edge/condition decode
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl};
      sda_sync <= {sda_sync[0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sda_low    <= 1'b0;
      shift      <= '0;
      tx_byte    <= '0;
      reg_ptr    <= '0;
      cnt        <= '0;
      snapshot   <= '0;
      rw         <= 1'b0;
      ack_drv    <= 1'b0;
      ptr_loaded <= 1'b0;
      done_flag  <= 1'b0;
      busy       <= 1'b0;
      read_done  <= 1'b0;
    end else begin
      read_done <= 1'b0;
      if (stop_c) begin
        state     <= IDLE;
        sda_low   <= 1'b0;
        busy      <= 1'b0;
        read_done <= done_flag;
        done_flag <= 1'b0;
      end else if (start_c) begin
        state      <= ADDR;
        sda_low    <= 1'b0;
        cnt        <= '0;
        ack_drv    <= 1'b0;
        ptr_loaded <= 1'b0;
        done_flag  <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise_c) begin
            shift <= byte_in_c[BYTE_W-2:0];
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              if (byte_in_c[7:1] == DEV_ADDR) begin
                busy    <= 1'b1;
                rw      <= byte_in_c[0];
                ack_drv <= 1'b0;
                state   <= ACK;
                if (byte_in_c[0]) snapshot <= bus.raw_angle;
              end else begin
                busy  <= 1'b0;
                state <= WAIT;
              end
            end
          end
          // First falling edge pulls the ACK, second releases it and starts the next byte
          ACK: if (scl_fall_c) begin
            if (!ack_drv) begin
              sda_low <= 1'b1;
              ack_drv <= 1'b1;
            end else begin
              ack_drv <= 1'b0;
              cnt     <= '0;
              if (rw) begin
                state   <= TX;
                tx_byte <= cur_byte_c;
                sda_low <= ~cur_byte_c[7];
              end else begin
                state   <= PTR;
                sda_low <= 1'b0;
              end
            end
          end
          PTR: if (scl_rise_c) begin
            shift <= byte_in_c[BYTE_W-2:0];
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              if (!ptr_loaded) begin
                reg_ptr    <= byte_in_c;
                ptr_loaded <= 1'b1;
              end
              state <= ACK;
            end
          end
          // cnt==8 marks the initiator's ACK slot after the 8th data bit
          TX: begin
            if (scl_rise_c) begin
              if (cnt[3]) begin
                reg_ptr   <= reg_ptr + 8'd1;
                done_flag <= 1'b1;
                cnt       <= '0;
                if (sda_s) state   <= WAIT;
                else       tx_byte <= nxt_byte_c;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else if (scl_fall_c) begin
              if (cnt[3]) sda_low <= 1'b0;
              else        sda_low <= ~tx_bit_c;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_as5600_i2c_target.sv
// Directed bench for as5600_i2c_target: a bit-banged I2C initiator on a pulled-up SDA
// exercises pointer writes, reads, address mismatch, snapshot coherence and aborts.
module tb_as5600_i2c_target;
  localparam int unsigned Q = 50;

  logic clock;
  logic reset_n;
  logic m_low;
  wire  sda;
  int   checks;
  int   errors;
  int   rd_pulses;

  as5600_i2c_target_if bus();

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  as5600_i2c_target #(.DEV_ADDR(7'h36)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .sda     (sda)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (bus.read_done === 1'b1) rd_pulses++;

  task automatic i2c_start();
    if (bus.scl == 1'b0) begin
      m_low = 1'b0; #(Q); bus.scl = 1'b1; #(Q);
    end
    m_low = 1'b1; #(Q); bus.scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #(Q); bus.scl = 1'b1; #(Q); m_low = 1'b0; #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; #(Q); bus.scl = 1'b1; #(2*Q); bus.scl = 1'b0; #(Q);
    end
    m_low = 1'b0; #(Q); bus.scl = 1'b1; #(Q);
    acked = (sda === 1'b0);
    #(Q); bus.scl = 1'b0; #(Q);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; #(Q); bus.scl = 1'b1; #(Q); b[i] = sda; #(Q); bus.scl = 1'b0; #(Q);
    end
    m_low = ack; #(Q); bus.scl = 1'b1; #(2*Q); bus.scl = 1'b0; #(Q);
  endtask

  // Write pointer, repeated START, then read address; leaves the bus in the first TX byte
  task automatic ptr_then_read_addr(input logic [7:0] ptr, output logic [2:0] acks);
    logic a;
    i2c_start(); send_byte(8'h6C, a); acks[2] = a;
    send_byte(ptr, a); acks[1] = a;
    i2c_start(); send_byte(8'h6D, a); acks[0] = a;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; m_low = 1'b0; bus.scl = 1'b1; bus.raw_angle = 12'h000;
    #(2*Q);
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", sda); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.read_done !== 1'b0) begin errors++; $display("FAIL reset_read_done: got %b expected 0", bus.read_done); end
    checks++; if (bus.reg_ptr !== 8'h00) begin errors++; $display("FAIL reset_reg_ptr: got %h expected 00", bus.reg_ptr); end
    reset_n = 1'b1; #(2*Q);
  endtask

  task automatic test_ptr_read();
    logic [2:0] acks;
    logic [7:0] b0, b1;
    int n0;
    bus.raw_angle = 12'hABC;
    n0 = rd_pulses;
    ptr_then_read_addr(8'h0C, acks);
    checks++; if (acks !== 3'b111) begin errors++; $display("FAIL ptr_read_acks: got %b expected 111", acks); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ptr_read_busy: got %b expected 1", bus.busy); end
    read_byte(1'b1, b0);
    read_byte(1'b0, b1);
    checks++; if (b0 !== 8'h0A) begin errors++; $display("FAIL ptr_read_byte0: got %h expected 0a", b0); end
    checks++; if (b1 !== 8'hBC) begin errors++; $display("FAIL ptr_read_byte1: got %h expected bc", b1); end
    checks++; if (bus.reg_ptr !== 8'h0E) begin errors++; $display("FAIL ptr_read_reg_ptr: got %h expected 0e", bus.reg_ptr); end
    i2c_stop();
    checks++; if (rd_pulses - n0 !== 1) begin errors++; $display("FAIL ptr_read_done_pulses: got %0d expected 1", rd_pulses - n0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ptr_read_busy_after_stop: got %b expected 0", bus.busy); end
  endtask

  task automatic test_addr_mismatch();
    logic a;
    int n0;
    n0 = rd_pulses;
    i2c_start();
    send_byte(8'h6E, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL mismatch_addr_ack: got %b expected 0", a); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b expected 0", bus.busy); end
    send_byte(8'hFF, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL mismatch_data_ack: got %b expected 0", a); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy_late: got %b expected 0", bus.busy); end
    i2c_stop();
    checks++; if (rd_pulses - n0 !== 0) begin errors++; $display("FAIL mismatch_read_done: got %0d expected 0", rd_pulses - n0); end
  endtask

  task automatic test_snapshot();
    logic [2:0] acks;
    logic [7:0] b0, b1;
    bus.raw_angle = 12'hABC;
    ptr_then_read_addr(8'h0C, acks);
    read_byte(1'b1, b0);
    bus.raw_angle = 12'h123;
    read_byte(1'b0, b1);
    i2c_stop();
    checks++; if (b0 !== 8'h0A) begin errors++; $display("FAIL snapshot_byte0: got %h expected 0a", b0); end
    checks++; if (b1 !== 8'hBC) begin errors++; $display("FAIL snapshot_byte1: got %h expected bc", b1); end
    ptr_then_read_addr(8'h0C, acks);
    read_byte(1'b1, b0);
    read_byte(1'b0, b1);
    i2c_stop();
    checks++; if (acks !== 3'b111) begin errors++; $display("FAIL snapshot_acks: got %b expected 111", acks); end
    checks++; if (b0 !== 8'h01) begin errors++; $display("FAIL snapshot_next_byte0: got %h expected 01", b0); end
    checks++; if (b1 !== 8'h23) begin errors++; $display("FAIL snapshot_next_byte1: got %h expected 23", b1); end
  endtask

  task automatic test_ptr_wrap();
    logic [2:0] acks;
    logic [7:0] b0, b1;
    bus.raw_angle = 12'hFFF;
    ptr_then_read_addr(8'hFF, acks);
    read_byte(1'b1, b0);
    read_byte(1'b0, b1);
    checks++; if (b0 !== 8'h00) begin errors++; $display("FAIL wrap_byte0: got %h expected 00", b0); end
    checks++; if (b1 !== 8'h00) begin errors++; $display("FAIL wrap_byte1: got %h expected 00", b1); end
    checks++; if (bus.reg_ptr !== 8'h01) begin errors++; $display("FAIL wrap_reg_ptr: got %h expected 01", bus.reg_ptr); end
    i2c_stop();
  endtask

  task automatic test_reset_mid();
    logic [2:0] acks;
    logic [7:0] b0;
    bus.raw_angle = 12'hABC;
    ptr_then_read_addr(8'h0C, acks);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rstmid_driving: got %b expected 0", sda); end
    reset_n = 1'b0;
    #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rstmid_sda_released: got %b expected 1", sda); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.reg_ptr !== 8'h00) begin errors++; $display("FAIL rstmid_reg_ptr: got %h expected 00", bus.reg_ptr); end
    bus.scl = 1'b1;
    #(Q-1);
    reset_n = 1'b1;
    #(2*Q);
    bus.raw_angle = 12'h5A5;
    ptr_then_read_addr(8'h0D, acks);
    read_byte(1'b0, b0);
    i2c_stop();
    checks++; if (acks !== 3'b111) begin errors++; $display("FAIL rstmid_acks: got %b expected 111", acks); end
    checks++; if (b0 !== 8'hA5) begin errors++; $display("FAIL rstmid_byte: got %h expected a5", b0); end
  endtask

  task automatic test_rs_mid_tx();
    logic [2:0] acks;
    logic [1:0] bits;
    logic a;
    int n0;
    bus.raw_angle = 12'hABC;
    ptr_then_read_addr(8'h0D, acks);
    n0 = rd_pulses;
    for (int i = 1; i >= 0; i--) begin
      m_low = 1'b0; #(Q); bus.scl = 1'b1; #(Q); bits[i] = sda; #(Q); bus.scl = 1'b0; #(Q);
    end
    checks++; if (bits !== 2'b10) begin errors++; $display("FAIL rs_first_bits: got %b expected 10", bits); end
    m_low = 1'b0; #(Q); bus.scl = 1'b1; #(Q);
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rs_sda_before_start: got %b expected 1", sda); end
    m_low = 1'b1; #(Q); bus.scl = 1'b0; #(Q);
    checks++; if (bus.reg_ptr !== 8'h0D) begin errors++; $display("FAIL rs_reg_ptr: got %h expected 0d", bus.reg_ptr); end
    send_byte(8'h6C, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rs_new_addr_ack: got %b expected 1", a); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rs_busy: got %b expected 1", bus.busy); end
    i2c_stop();
    checks++; if (rd_pulses - n0 !== 0) begin errors++; $display("FAIL rs_read_done: got %0d expected 0", rd_pulses - n0); end
    checks++; if (bus.reg_ptr !== 8'h0D) begin errors++; $display("FAIL rs_reg_ptr_after: got %h expected 0d", bus.reg_ptr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rs_busy_after_stop: got %b expected 0", bus.busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd_pulses = 0;
    test_reset();
    test_ptr_read();
    test_addr_mismatch();
    test_snapshot();
    test_ptr_wrap();
    test_reset_mid();
    test_rs_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/as5600_i2c_target.md
# as5600_i2c_target

I2C target (responder) that emulates the AS5600 magnetic encoder's angle registers. It answers the I2C read transactions issued by the encoder-read side of the swerve PWM control path. It serves as the sensor model in block- and system-level benches, and as an on-FPGA angle source when driven from a test angle register. It oversamples SCL/SDA on the system clock, decodes START/STOP/address/pointer, and shifts out a coherent 12-bit angle snapshot.

## Interface
- DEV_ADDR, 7'h36, 7-bit target address matched on the bus.
- clock  input  1  main clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- raw_angle  input  12  angle presented in registers 0x0C–0x0F.
- scl  input  1  I2C clock from the initiator.
- sda  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
- reg_ptr  output  8  current register pointer.
- busy  output  1  high from address match until STOP, or until a START not addressed to us.
- read_done  output  1  one-cycle pulse at STOP ending a read that transmitted at least 1 byte.

## Operation
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer plus a previous-value flop.
  - Edges and conditions are decoded from the synchronized values.
- Bus conditions:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Both are detected in every state.
  - START in any state goes to ADDR (repeated START supported).
  - STOP in any state goes to IDLE.
- Sampling and driving:
  - Bits are sampled on the synchronized scl rising edge, MSB first.
  - The target changes sda only on the synchronized scl falling edge.
- States:
  - IDLE: sda released. Wait for START.
  - ADDR: shift 8 bits. If bits[7:1]==DEV_ADDR, ACK. With R/W=0 go to PTR; with R/W=1, capture snapshot <= raw_angle and go to TX. On mismatch, NACK (keep sda released) and go to WAIT.
  - ACK: drive sda low from the falling edge after bit 8 until the falling edge after bit 9.
  - PTR: shift 8 bits into reg_ptr, then ACK. Further write bytes are ACKed and discarded; reg_ptr is not changed by them.
  - TX: load the byte for reg_ptr and drive its bits on falling edges. After the 8th bit, release sda for the initiator's ACK. Sample ACK/NACK on the 9th rising edge, then reg_ptr <= reg_ptr+1 (8-bit wrap, 0xFF->0x00).
    - ACK: load the next byte and continue in TX.
    - NACK: go to WAIT.
  - WAIT: sda released. Ignore everything until START or STOP.
- Register map (from snapshot):
  - 0x0C and 0x0E = {4'h0, snap[11:8]}.
  - 0x0D and 0x0F = snap[7:0].
  - All other addresses read 8'h00.
- Snapshot: captured only on a read address match. It stays constant for the whole read, so the high and low bytes are coherent.
- read_done:
  - A flag is set when the first TX byte completes.
  - The pulse fires on STOP if the flag is set.
  - The flag is cleared on any START.

## Timing
- Reset values:
  - sda released (z); busy=0; read_done=0; reg_ptr=8'h00.
  - snapshot=12'h000; state=IDLE; synchronizer flops=1.
- Reset is asynchronous: sda is released within the same cycle reset_n falls.
- Pin-to-detect latency: 3 clocks (2 sync + 1 edge).
- sda output changes within 4 clocks of the scl falling edge at the pin.
- Clock requirement: clock ≥ 8× SCL frequency.
- busy timing:
  - Rises the cycle after ADDR bit 8 is sampled with a match.
  - Falls the cycle after STOP is detected.
- read_done fires 1 clock after STOP detection; width is exactly 1 clock.
- A START or STOP arriving mid-byte aborts that byte: sda is released, nothing is ACKed, and reg_ptr is not incremented.

## Test plan
- Pointer then read: write ptr 0x0C, repeated START, read 2 bytes with raw_angle=12'hABC, initiator ACK then NACK, STOP.
  - Expect ACK on address and on pointer; bytes 0x0A, 0xBC.
  - Expect reg_ptr=0x0E after the read and one read_done pulse.
- Address mismatch: send address 0x37.
  - Expect sda high on the 9th clock, busy stays 0, no sda drive until the next START.
- Snapshot coherence: after the address phase, change raw_angle from 12'hABC to 12'h123 between bytes.
  - Expect bytes 0x0A, 0xBC.
  - A following read transaction returns 0x01, 0x23.
- Pointer wrap: write ptr 0xFF, read 2 bytes.
  - Expect 0x00, 0x00; reg_ptr=0x01.
- Reset mid-transfer: assert reset_n low while the target drives sda low in TX.
  - Expect sda=z immediately, busy=0, reg_ptr=0x00.
  - Next full read (ptr 0x0D, raw_angle=12'h5A5) returns 0xA5.
- Repeated START mid-byte during TX.
  - Expect sda released, no read_done.
  - Expect reg_ptr unchanged; the new address phase is ACKed normally.
